dense_layer: RTL and testbench

Fully-connected output layer of the modulation-recognition CNN. Consumes one 128-element feature vector, one sample per clock, in signed Q3.12. Produces 11 class scores (neurons 0..10), also Q3.12, streamed out serially. Weights and biases live in on-chip ROMs initialised from hex files. No activation is applied; softmax/argmax happen downstream.

---
 rtl/dense_layer_pkg.sv | 30 +++
 rtl/dense_layer_if.sv | 24 ++
 rtl/dense_layer_mac_lane.sv | 37 +++
 rtl/dense_layer.sv | 140 ++++++++++++++
 tb/tb_dense_layer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_layer_pkg.sv
// Shared constants, types and the Q3.12 saturation helper for the dense output layer.
package dense_pkg;

  localparam int N_IN  = 128;
  localparam int N_OUT = 11;
  localparam int DW    = 16;
  localparam int FRAC  = 12;
  localparam int ACC_W = 40;

  localparam logic signed [DW-1:0]    Q312_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0]    Q312_MIN = 16'sh8000;
  localparam logic signed [ACC_W-1:0] SAT_HI   = {{(ACC_W-DW){1'b0}}, Q312_MAX};
  localparam logic signed [ACC_W-1:0] SAT_LO   = {{(ACC_W-DW){1'b1}}, Q312_MIN};

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } stream_state_t;

  function automatic logic signed [DW-1:0] sat_q312(input logic signed [ACC_W-1:0] x);
    if (x > SAT_HI) begin
      return Q312_MAX;
    end else if (x < SAT_LO) begin
      return Q312_MIN;
    end else begin
      return x[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/dense_layer_if.sv
// Sample stream into the dense layer and score stream out of it.
interface dense_layer_if;
  import dense_pkg::*;

  logic signed [DW-1:0] dense_din;
  logic                 dense_din_vld;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;

  modport master (
    output dense_din,
    output dense_din_vld,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  dense_din,
    input  dense_din_vld,
    output dout,
    output dout_valid
  );

endinterface

// File: rtl/dense_layer_mac_lane.sv
// One neuron's multiply-accumulate lane: registered product plus a clearable accumulator.
module dense_mac_lane
  import dense_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    prod_en,
  input  logic signed [DW-1:0]    din,
  input  logic signed [DW-1:0]    weight,
  input  logic                    acc_en,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;

  always_ff @(posedge clk) begin
    if (prod_en) begin
      prod <= din * weight;
    end
  end

  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  // On clear, a product already belonging to the next frame seeds the accumulator.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= acc_en ? prod_ext : '0;
    end else if (acc_en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/dense_layer.sv
// Fully-connected output layer: 128 Q3.12 inputs -> 11 Q3.12 scores, streamed serially.
// state     | meaning
// ST_IDLE   | no scores being streamed, dout held at 0
// ST_STREAM | bank entry out_idx presented on dout with dout_valid
module dense_layer
  import dense_pkg::*;
#(
  parameter string WEIGHT_FILE = "dense_weights.hex",
  parameter string BIAS_FILE   = "dense_bias.hex"
) (
  input logic          clk,
  input logic          rst_n,
  dense_layer_if.slave bus
);

  localparam int IDX_W  = $clog2(N_IN);
  localparam int OIDX_W = $clog2(N_OUT);

  logic [N_OUT*DW-1:0] weight_rom [N_IN];
  logic [DW-1:0]       bias_rom   [N_OUT];

  logic [IDX_W-1:0] idx;
  logic             last_in;

  assign last_in = (idx == IDX_W'(N_IN - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx <= '0;
    end else if (bus.dense_din_vld) begin
      idx <= last_in ? '0 : idx + IDX_W'(1);
    end
  end

  logic                 s1_vld, s1_last, s2_vld, s2_last, fin;
  logic signed [DW-1:0] s1_din;
  logic [N_OUT*DW-1:0]  s1_w;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      fin     <= 1'b0;
    end else begin
      s1_vld  <= bus.dense_din_vld;
      s1_last <= bus.dense_din_vld & last_in;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      fin     <= s2_last;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.dense_din_vld) begin
      s1_din <= bus.dense_din;
      s1_w   <= weight_rom[idx];
    end
  end

  logic signed [ACC_W-1:0] acc [N_OUT];

  for (genvar o = 0; o < N_OUT; o++) begin : g_lane
    dense_mac_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .prod_en (s1_vld),
      .din     (s1_din),
      .weight  (s1_w[o*DW +: DW]),
      .acc_en  (s2_vld),
      .clr     (fin),
      .acc     (acc[o])
    );
  end

  logic signed [ACC_W-1:0] sum   [N_OUT];
  logic signed [DW-1:0]    score [N_OUT];

  // Arithmetic shift floors toward -inf; no rounding term is added.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      sum[o]   = acc[o] + ($signed({{(ACC_W-DW){bias_rom[o][DW-1]}}, bias_rom[o]}) <<< FRAC);
      score[o] = sat_q312(sum[o] >>> FRAC);
    end
  end

  logic signed [DW-1:0] bank [N_OUT];

  always_ff @(posedge clk) begin
    if (fin) begin
      for (int o = 0; o < N_OUT; o++) begin
        bank[o] <= score[o];
      end
    end
  end

  stream_state_t     state, state_nxt;
  logic [OIDX_W-1:0] out_idx, out_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= ST_IDLE;
      out_idx <= '0;
    end else begin
      state   <= state_nxt;
      out_idx <= out_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    out_idx_nxt = out_idx;
    case (state)
      ST_IDLE: begin
        out_idx_nxt = '0;
      end
      ST_STREAM: begin
        if (out_idx == OIDX_W'(N_OUT - 1)) begin
          state_nxt   = ST_IDLE;
          out_idx_nxt = '0;
        end else begin
          out_idx_nxt = out_idx + OIDX_W'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        out_idx_nxt = '0;
      end
    endcase
    if (fin) begin
      state_nxt   = ST_STREAM;
      out_idx_nxt = '0;
    end
  end

  assign bus.dout_valid = (state == ST_STREAM);
  assign bus.dout       = (state == ST_STREAM) ? bank[out_idx] : '0;

endmodule

// File: tb/tb_dense_layer.sv
// Randomised bench for dense_layer against an integer-arithmetic reference of the layer.
module tb_dense_layer;
  import dense_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dense_layer_if bus ();

  dense_layer #(
    .WEIGHT_FILE (""),
    .BIAS_FILE   ("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  shortint w_mdl [N_OUT][N_IN];
  shortint b_mdl [N_OUT];
  shortint frame [N_IN];
  shortint vec   [N_IN];
  int      n_acc = 0;

  typedef struct {
    int      cyc;
    shortint val;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Score = floor((sum W*x + bias*2^12) / 2^12), clipped to 16-bit signed.
  function automatic shortint ref_score(input int o);
    longint s;
    longint q;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += longint'(w_mdl[o][i]) * longint'(frame[i]);
    s += longint'(b_mdl[o]) * 4096;
    q = s / 4096;
    if ((s % 4096 != 0) && (s < 0)) q -= 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return shortint'(q);
  endfunction

  task automatic load_rom();
    logic [N_OUT*DW-1:0] word;
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) word[o*DW +: DW] = w_mdl[o][i];
      dut.weight_rom[i] = word;
    end
    for (int o = 0; o < N_OUT; o++) dut.bias_rom[o] = b_mdl[o];
  endtask

  task automatic set_weights(input int mag, input int bmag);
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++)
        w_mdl[o][i] = shortint'(int'($urandom_range(0, 2*mag)) - mag);
      b_mdl[o] = shortint'(int'($urandom_range(0, 2*bmag)) - bmag);
    end
    load_rom();
  endtask

  task automatic set_const_weights(input shortint w);
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) w_mdl[o][i] = w;
      b_mdl[o] = 0;
    end
    load_rom();
  endtask

  task automatic send(input shortint d, input bit v);
    @(negedge clk);
    bus.dense_din     = d;
    bus.dense_din_vld = v;
    if (v) begin
      frame[n_acc] = d;
      n_acc++;
      if (n_acc == N_IN) begin
        for (int o = 0; o < N_OUT; o++) exp_q.push_back('{cyc: cyc + 4 + o, val: ref_score(o)});
        n_acc = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(shortint'($urandom()), 1'b0);
  endtask

  task automatic send_vec(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) send(shortint'($urandom()), 1'b0);
      send(vec[i], 1'b1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    idle(3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    mon_en            = 1'b0;
    rst_n             = 1'b1;
    bus.dense_din_vld = 1'b0;
    repeat (n) @(negedge clk);
    rst_n  = 1'b0;
    exp_q.delete();
    n_acc  = 0;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", bus.dout_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("valid_cycle", cyc, mon_e.cyc);
          chk("dout", bus.dout, mon_e.val);
        end
      end else begin
        chk("idle_dout", bus.dout, 0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("dout_valid", bus.dout_valid, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.dense_din     = '0;
    bus.dense_din_vld = 1'b0;
    set_const_weights(0);
    do_reset(3);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);

    // identity weights, ramp input -> 0x0000, 0x0010, ... 0x00A0
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) w_mdl[o][i] = (i == o) ? shortint'(16'h1000) : 16'sh0;
      b_mdl[o] = 0;
    end
    load_rom();
    for (int i = 0; i < N_IN; i++) vec[i] = shortint'(i * 16);
    send_vec(N_IN, 0);
    drain();

    // bias only
    set_weights(32767, 32767);
    for (int i = 0; i < N_IN; i++) vec[i] = 0;
    send_vec(N_IN, 0);
    drain();

    // saturation, two frames back to back
    set_const_weights(shortint'(16'h1000));
    for (int i = 0; i < N_IN; i++) vec[i] = shortint'(16'h1000);
    send_vec(N_IN, 0);
    for (int i = 0; i < N_IN; i++) vec[i] = shortint'(16'hF000);
    send_vec(N_IN, 0);
    drain();

    // truncation of a single tiny product
    set_const_weights(1);
    for (int i = 0; i < N_IN; i++) vec[i] = 0;
    vec[$urandom_range(0, N_IN-1)] = 1;
    send_vec(N_IN, 0);
    for (int i = 0; i < N_IN; i++) vec[i] = 0;
    vec[$urandom_range(0, N_IN-1)] = -1;
    send_vec(N_IN, 0);
    drain();

    // gapped versus contiguous delivery of the same frame
    set_weights(2048, 4096);
    for (int i = 0; i < N_IN; i++) vec[i] = shortint'($urandom());
    send_vec(N_IN, 40);
    drain();
    send_vec(N_IN, 0);
    drain();

    // reset mid-frame discards the partial frame
    for (int i = 0; i < N_IN; i++) vec[i] = shortint'($urandom());
    send_vec(60, 10);
    do_reset(2);
    send_vec(N_IN, 0);
    drain();

    // reset mid-stream aborts the stream
    send_vec(N_IN, 0);
    idle(8);
    do_reset(1);
    chk("abort_dout_valid", bus.dout_valid, 0);
    idle(20);

    // regression: groups of frames with random gaps, including zero gaps
    for (int g = 0; g < 6; g++) begin
      case (g % 3)
        0:       set_weights(32767, 32767);
        1:       set_weights(1024, 8192);
        default: set_weights(64, 2048);
      endcase
      for (int f = 0; f < 5; f++) begin
        for (int i = 0; i < N_IN; i++) vec[i] = shortint'($urandom());
        send_vec(N_IN, (g % 2 == 0) ? 0 : 15);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
      end
      drain();
    end

    idle(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
